tdm_demux_4ch: RTL and testbench

Four-channel time-division demultiplexer, the receive-side counterpart of the 4:1 select mux. Accepts a serial stream of DW-bit words in a repeating 4-slot frame (slot 0 marked by `sync`), tracks the slot with an internal 2-bit counter, and presents all four channel words in parallel once per frame with a one-cycle `frame_valid` strobe. Includes sync hunting, lock and lock-loss detection so the far-end mux can be started, stalled or restarted at any time.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_demux_4ch.sv | 138 +++++++++++++
 tb/tb_tdm_demux_4ch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM demultiplexer.
package tdm_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SLOT_W = 2;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/tdm_demux_4ch.sv
// 4-slot TDM receiver: hunts for sync, tracks the slot, and presents each
// complete frame on y0..y3 with a one-cycle frame_valid strobe.
module tdm_demux_4ch
   import tdm_pkg::*;
#(
   parameter int unsigned DW       = 1,
   parameter int unsigned MISS_MAX = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   input  logic          sync,
   output logic [DW-1:0] y0,
   output logic [DW-1:0] y1,
   output logic [DW-1:0] y2,
   output logic [DW-1:0] y3,
   output logic          frame_valid,
   output logic          s1,
   output logic          s0,
   output logic          locked,
   output logic          sync_err
);

   localparam int unsigned MISS_W = 3;
   localparam int unsigned NUM_SH = NUM_CH - 1;

   tdm_state_t          state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
   logic [DW-1:0]       shadow_q [NUM_SH];
   logic [DW-1:0]       shadow_d [NUM_SH];
   logic [DW-1:0]       y0_d, y1_d, y2_d, y3_d;
   logic                fv_d, se_d, locked_d;

   assign s1       = slot_q[1];
   assign s0       = slot_q[0];
   assign miss_inc = miss_q + MISS_W'(1);

   // Next-state, slot tracking and frame assembly
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      miss_d   = miss_q;
      shadow_d = shadow_q;
      y0_d     = y0;
      y1_d     = y1;
      y2_d     = y2;
      y3_d     = y3;
      fv_d     = 1'b0;
      se_d     = 1'b0;

      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (sync) begin
                  shadow_d[0] = din;
                  slot_d      = SLOT_W'(1);
                  miss_d      = '0;
                  state_d     = LOCKED;
               end
            end
            LOCKED: begin
               if (sync && (slot_q != '0)) begin
                  // Early sync realigns: partial frame dropped, beat becomes ch0
                  se_d        = 1'b1;
                  shadow_d[0] = din;
                  slot_d      = SLOT_W'(1);
                  miss_d      = '0;
               end else begin
                  case (slot_q)
                     SLOT_W'(0): begin
                        if (!sync && (miss_inc >= MISS_W'(MISS_MAX))) begin
                           state_d = HUNT;
                           slot_d  = '0;
                           miss_d  = '0;
                        end else begin
                           shadow_d[0] = din;
                           slot_d      = SLOT_W'(1);
                           miss_d      = sync ? '0 : miss_inc;
                        end
                     end
                     SLOT_W'(1): begin
                        shadow_d[1] = din;
                        slot_d      = SLOT_W'(2);
                     end
                     SLOT_W'(2): begin
                        shadow_d[2] = din;
                        slot_d      = SLOT_W'(3);
                     end
                     default: begin
                        y0_d   = shadow_q[0];
                        y1_d   = shadow_q[1];
                        y2_d   = shadow_q[2];
                        y3_d   = din;
                        fv_d   = 1'b1;
                        slot_d = '0;
                     end
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HUNT;
         slot_q      <= '0;
         miss_q      <= '0;
         for (int i = 0; i < NUM_SH; i++) shadow_q[i] <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         miss_q      <= miss_d;
         shadow_q    <= shadow_d;
         y0          <= y0_d;
         y1          <= y1_d;
         y2          <= y2_d;
         y3          <= y3_d;
         frame_valid <= fv_d;
         sync_err    <= se_d;
         locked      <= locked_d;
      end
   end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Table-driven bench for tdm_demux_4ch: one vector per clock, outputs checked
// just after each rising edge against hand-computed expectations.
module tb_tdm_demux_4ch;

   logic       clk;
   logic       reset;
   logic [0:0] din;
   logic       din_valid;
   logic       sync;
   logic [0:0] y0, y1, y2, y3;
   logic       frame_valid, s1, s0, locked, sync_err;

   int n_vec;
   int n_err;

   // {rst, vld, din, sync, expected {y0,y1,y2,y3, fv, slot[1:0], locked, sync_err}}
   typedef struct packed {
      logic       rst;
      logic       vld;
      logic       d;
      logic       syn;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   tdm_demux_4ch #(.DW(1), .MISS_MAX(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .y0         (y0),
      .y1         (y1),
      .y2         (y2),
      .y3         (y3),
      .frame_valid(frame_valid),
      .s1         (s1),
      .s0         (s0),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic v, input logic d, input logic s,
                      input logic [3:0] y, input logic fv, input logic [1:0] sl,
                      input logic lk, input logic se);
      vec_t t;
      t.rst = r;
      t.vld = v;
      t.d   = d;
      t.syn = s;
      t.exp = {y, fv, sl, lk, se};
      vecs.push_back(t);
   endtask

   task automatic step_check(input string tag, input logic r, input logic v,
                             input logic d, input logic s, input logic [8:0] exp);
      logic [8:0] act;
      @(negedge clk);
      reset     = r;
      din_valid = v;
      din       = d;
      sync      = s;
      @(posedge clk);
      #1;
      act = {y0, y1, y2, y3, frame_valid, s1, s0, locked, sync_err};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got y/fv/slot/lk/se=%b required %b", tag, act, exp);
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      din_valid = 1'b0;
      din       = 1'b0;
      sync      = 1'b0;

      // reset, including reset overriding a valid sync beat
      add(1,0,0,0, 4'b0000,0,2'd0,0,0);
      add(1,1,1,1, 4'b0000,0,2'd0,0,0);
      // frame 0,1,0,0 from HUNT
      add(0,1,0,1, 4'b0000,0,2'd1,1,0);
      add(0,1,1,0, 4'b0000,0,2'd2,1,0);
      add(0,1,0,0, 4'b0000,0,2'd3,1,0);
      add(0,1,0,0, 4'b0100,1,2'd0,1,0);
      // back-to-back frames 1,1,1,0 and 0,0,1,0
      add(0,1,1,1, 4'b0100,0,2'd1,1,0);
      add(0,1,1,0, 4'b0100,0,2'd2,1,0);
      add(0,1,1,0, 4'b0100,0,2'd3,1,0);
      add(0,1,0,0, 4'b1110,1,2'd0,1,0);
      add(0,1,0,1, 4'b1110,0,2'd1,1,0);
      add(0,1,0,0, 4'b1110,0,2'd2,1,0);
      add(0,1,1,0, 4'b1110,0,2'd3,1,0);
      add(0,1,0,0, 4'b0010,1,2'd0,1,0);
      // frame 1,0,1,1 with invalid gaps (garbage din/sync during gaps)
      add(0,1,1,1, 4'b0010,0,2'd1,1,0);
      add(0,0,0,1, 4'b0010,0,2'd1,1,0);
      add(0,1,0,0, 4'b0010,0,2'd2,1,0);
      add(0,0,1,1, 4'b0010,0,2'd2,1,0);
      add(0,0,1,0, 4'b0010,0,2'd2,1,0);
      add(0,1,1,0, 4'b0010,0,2'd3,1,0);
      add(0,0,0,1, 4'b0010,0,2'd3,1,0);
      add(0,1,1,0, 4'b1011,1,2'd0,1,0);
      add(0,0,0,0, 4'b1011,0,2'd0,1,0);
      // sync on slot 2: realign, partial frame dropped
      add(0,1,0,1, 4'b1011,0,2'd1,1,0);
      add(0,1,1,0, 4'b1011,0,2'd2,1,0);
      add(0,1,1,1, 4'b1011,0,2'd1,1,1);
      add(0,1,0,0, 4'b1011,0,2'd2,1,0);
      add(0,1,0,0, 4'b1011,0,2'd3,1,0);
      add(0,1,1,0, 4'b1001,1,2'd0,1,0);
      // first missed sync: frame still decoded
      add(0,1,0,0, 4'b1001,0,2'd1,1,0);
      add(0,1,1,0, 4'b1001,0,2'd2,1,0);
      add(0,1,1,0, 4'b1001,0,2'd3,1,0);
      add(0,1,0,0, 4'b0110,1,2'd0,1,0);
      // second missed sync: lock lost, then HUNT ignores non-sync beats
      add(0,1,1,0, 4'b0110,0,2'd0,0,0);
      add(0,1,1,0, 4'b0110,0,2'd0,0,0);
      add(0,1,0,0, 4'b0110,0,2'd0,0,0);
      add(0,1,1,0, 4'b0110,0,2'd0,0,0);
      // relock on next sync frame 1,1,0,1
      add(0,1,1,1, 4'b0110,0,2'd1,1,0);
      add(0,1,1,0, 4'b0110,0,2'd2,1,0);
      add(0,1,0,0, 4'b0110,0,2'd3,1,0);
      add(0,1,1,0, 4'b1101,1,2'd0,1,0);

      for (int i = 0; i < vecs.size(); i++)
         step_check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].vld,
                    vecs[i].d, vecs[i].syn, vecs[i].exp);

      // reset after two beats of a frame, then clean decode
      step_check("rstmid_b0",   0,1,1,1, {4'b1101,1'b0,2'd1,1'b1,1'b0});
      step_check("rstmid_b1",   0,1,0,0, {4'b1101,1'b0,2'd2,1'b1,1'b0});
      step_check("rstmid_rst",  1,1,1,1, {4'b0000,1'b0,2'd0,1'b0,1'b0});
      step_check("rstmid_hunt", 0,1,1,0, {4'b0000,1'b0,2'd0,1'b0,1'b0});
      step_check("rstmid_f0",   0,1,0,1, {4'b0000,1'b0,2'd1,1'b1,1'b0});
      step_check("rstmid_f1",   0,1,1,0, {4'b0000,1'b0,2'd2,1'b1,1'b0});
      step_check("rstmid_f2",   0,1,1,0, {4'b0000,1'b0,2'd3,1'b1,1'b0});
      step_check("rstmid_f3",   0,1,0,0, {4'b0110,1'b1,2'd0,1'b1,1'b0});

      // one miss, then a sync frame clears the miss count
      step_check("miss1_f0",    0,1,1,0, {4'b0110,1'b0,2'd1,1'b1,1'b0});
      step_check("miss1_f1",    0,1,0,0, {4'b0110,1'b0,2'd2,1'b1,1'b0});
      step_check("miss1_f2",    0,1,0,0, {4'b0110,1'b0,2'd3,1'b1,1'b0});
      step_check("miss1_f3",    0,1,1,0, {4'b1001,1'b1,2'd0,1'b1,1'b0});
      step_check("resync_f0",   0,1,0,1, {4'b1001,1'b0,2'd1,1'b1,1'b0});
      step_check("resync_f1",   0,1,0,0, {4'b1001,1'b0,2'd2,1'b1,1'b0});
      step_check("resync_f2",   0,1,0,0, {4'b1001,1'b0,2'd3,1'b1,1'b0});
      step_check("resync_f3",   0,1,0,0, {4'b0000,1'b1,2'd0,1'b1,1'b0});
      step_check("miss_again",  0,1,1,0, {4'b0000,1'b0,2'd1,1'b1,1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
